// File: rtl/seg_digit_sequencer_if.sv
// Bundle of the handshake, value and display signals of seg_digit_sequencer.
// The master side (value source / testbench) drives start, value and repeat_en;
// the slave side (the sequencer) drives busy, done and the 7-segment outputs.
interface seg_digit_sequencer_if #(
   parameter int DIGITS = 4
);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic                  start;
   logic [4*DIGITS-1:0]   value;
   logic                  repeat_en;
   logic                  busy;
   logic                  done;
   logic [6:0]            segments;
   logic                  dp;
   logic [IW-1:0]         digit_idx;

   modport master (
      output start, value, repeat_en,
      input  busy, done, segments, dp, digit_idx
   );

   modport slave (
      input  start, value, repeat_en,
      output busy, done, segments, dp, digit_idx
   );
endinterface

// File: rtl/seg_digit_sequencer.sv
// Time-multiplexes a multi-digit BCD value onto a single 7-segment display.
// Digits are shown most significant first, each lit for SHOW_TICKS cycles,
// separated by GAP_TICKS blank cycles, with PAUSE_TICKS blank cycles after the
// last digit. Leading zeros can be skipped; the value is held in a shadow
// register so that changes at the source do not disturb a running sequence.
module seg_digit_sequencer #(
   parameter int DIGITS         = 4,
   parameter int SHOW_TICKS     = 100,
   parameter int GAP_TICKS      = 20,
   parameter int PAUSE_TICKS    = 200,
   parameter int SUPPRESS_ZEROS = 1
) (
   input logic                   clk,
   input logic                   rst,
   seg_digit_sequencer_if.slave  bus
);

   localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int MAXT_SG = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
   localparam int MAXT    = (MAXT_SG > PAUSE_TICKS) ? MAXT_SG : PAUSE_TICKS;
   localparam int TW      = (MAXT > 0) ? $clog2(MAXT + 1) : 1;

   // The timer is loaded with (length - 1) on entry and the state ends when it reads zero.
   localparam logic [TW-1:0] SHOW_LOAD  = TW'(SHOW_TICKS - 1);
   localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_TICKS - 1);
   localparam logic [TW-1:0] PAUSE_LOAD = TW'(PAUSE_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      GAP   = 2'd2,
      PAUSE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [6:0]          segments_q, segments_d;
   logic                dp_q, dp_d;

   // Segment pattern for one digit; anything above 9 shows a dash.
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      s = 7'h40;
      case (d)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   // Picks the nibble of v selected by idx.
   function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] v,
                                           input logic [IW-1:0] idx);
      logic [3:0] d;
      d = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            d = v[4*i +: 4];
         end
      end
      return d;
   endfunction

   // Index of the first digit to show: the top digit, or with suppression the
   // most significant non-zero digit (non-BCD nibbles count as non-zero),
   // falling back to digit 0 when every digit is zero.
   function automatic logic [IW-1:0] first_idx(input logic [4*DIGITS-1:0] v);
      logic [IW-1:0] r;
      r = '0;
      if (SUPPRESS_ZEROS != 0) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'h0) begin
               r = IW'(i);
            end
         end
      end else begin
         r = IW'(DIGITS - 1);
      end
      return r;
   endfunction

   // State register and all registered outputs; reset returns everything to a blank idle display.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         idx_q      <= '0;
         shadow_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         segments_q <= 7'h00;
         dp_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         idx_q      <= idx_d;
         shadow_q   <= shadow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         segments_q <= segments_d;
         dp_q       <= dp_d;
      end
   end

   // Next-state logic; outputs are derived from the next state so that they line up with it once registered.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shadow_d = bus.value;
               idx_d    = first_idx(bus.value);
               timer_d  = SHOW_LOAD;
               state_d  = SHOW;
            end
         end

         SHOW: begin
            if (timer_q == '0) begin
               if (idx_q == '0) begin
                  timer_d = PAUSE_LOAD;
                  state_d = PAUSE;
               end else begin
                  timer_d = GAP_LOAD;
                  state_d = GAP;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end

         GAP: begin
            if (timer_q == '0) begin
               idx_d   = idx_q - IW'(1);
               timer_d = SHOW_LOAD;
               state_d = SHOW;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end

         PAUSE: begin
            if (timer_q == '0) begin
               done_d = 1'b1;
               if (bus.repeat_en) begin
                  shadow_d = bus.value;
                  idx_d    = first_idx(bus.value);
                  timer_d  = SHOW_LOAD;
                  state_d  = SHOW;
               end else begin
                  timer_d = '0;
                  state_d = IDLE;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end

         default: begin
            timer_d = '0;
            state_d = IDLE;
         end
      endcase

      busy_d     = (state_d != IDLE);
      segments_d = (state_d == SHOW) ? decode(digit_at(shadow_d, idx_d)) : 7'h00;
      dp_d       = (state_d == SHOW) && (idx_d == '0);
   end

   // Drive the interface straight from the registers.
   always_comb begin
      bus.busy      = busy_q;
      bus.done      = done_q;
      bus.segments  = segments_q;
      bus.dp        = dp_q;
      bus.digit_idx = idx_q;
   end

endmodule
